// File: rtl/cordic16_pkg.sv
// cordic16_pkg: shared constants for the 16-bit CORDIC rotation engine
package cordic16_pkg;
  localparam int W = 16;
  localparam int N_ITER = 16;
  localparam logic [W-1:0] K = 16'h26DD;
  localparam logic [N_ITER-1:0][W-1:0] ATAN = {
    16'h0000, 16'h0001, 16'h0002, 16'h0004,
    16'h0008, 16'h0010, 16'h0020, 16'h0040,
    16'h0080, 16'h0100, 16'h0200, 16'h03FF,
    16'h07F5, 16'h0FAE, 16'h1DAC, 16'h3244
  };
endpackage

// File: rtl/cordic_16_if.sv
// cordic_16_if: controller-to-engine signal bundle for the CORDIC leaf
interface cordic_16_if;
  logic [15:0] endangle;
  logic [3:0]  addr;
  logic        load;
  logic [15:0] sin;
  logic [15:0] cos;
  logic [15:0] data;
  logic [15:0] currentangle;
  modport master (output endangle, addr, load, input sin, cos, data, currentangle);
  modport slave (input endangle, addr, load, output sin, cos, data, currentangle);
endinterface

// File: rtl/cordic16_atan_rom.sv
// cordic16_atan_rom: atan(2^-addr) lookup in Q2.14
module cordic16_atan_rom
  import cordic16_pkg::*;
(
  input  logic [3:0]   addr,
  output logic [W-1:0] data
);
  // pure table lookup, no state
  always_comb data = ATAN[addr];
endmodule

// File: rtl/cordic_16.sv
// cordic_16: one CORDIC micro-rotation per clock, sequenced externally via addr
module cordic_16
  import cordic16_pkg::*;
(
  input logic        clock,
  input logic        reset,
  cordic_16_if.slave bus
);
  logic signed [W-1:0] x_q, y_q, z_q, t_q;
  logic signed [W-1:0] x_d, y_d, z_d, t_d;
  logic signed [W-1:0] x_s, y_s, z_s, t_s, x_sh, y_sh;
  logic [W-1:0] atan;
  logic dir;
  cordic16_atan_rom u_rom (.addr(bus.addr), .data(atan));
  // seed on load, else iterate from current state; ties rotate positive
  always_comb begin
    x_s = bus.load ? K : x_q;
    y_s = bus.load ? '0 : y_q;
    z_s = bus.load ? '0 : z_q;
    t_s = bus.load ? bus.endangle : t_q;
    dir = z_s <= t_s;
    x_sh = x_s >>> bus.addr;
    y_sh = y_s >>> bus.addr;
    x_d = dir ? x_s - y_sh : x_s + y_sh;
    y_d = dir ? y_s + x_sh : y_s - x_sh;
    z_d = dir ? z_s + atan : z_s - atan;
    t_d = t_s;
  end
  // state registers; reset wins over load
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      t_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      t_q <= t_d;
    end
  end
  assign bus.sin = y_q;
  assign bus.cos = x_q;
  assign bus.currentangle = z_q;
  assign bus.data = atan;
endmodule

// File: tb/tb_cordic_16.sv
// tb_cordic_16: directed table-driven checks of the CORDIC engine
module tb_cordic_16;
  logic clk = 0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  cordic_16_if bus ();
  cordic_16 dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } rom_vec_t;
  typedef struct {
    logic [15:0] ang;
    logic [15:0] s;
    logic [15:0] c;
  } seq_vec_t;
  rom_vec_t rv[16];
  seq_vec_t sv[4];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp, input int tol);
    int diff;
    diff = int'($signed(act)) - int'($signed(exp));
    n_chk++;
    if (diff > tol || diff < -tol) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (tol %0d)", nm, act, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] ang);
    bus.endangle = ang;
    bus.addr = 4'd0;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic run_seq(input logic [15:0] ang);
    start(ang);
    for (int i = 1; i < 16; i++) begin
      bus.addr = 4'(i);
      tick();
    end
  endtask

  initial begin
    rv = '{
      '{4'd0, 16'h3244}, '{4'd1, 16'h1DAC}, '{4'd2, 16'h0FAE}, '{4'd3, 16'h07F5},
      '{4'd4, 16'h03FF}, '{4'd5, 16'h0200}, '{4'd6, 16'h0100}, '{4'd7, 16'h0080},
      '{4'd8, 16'h0040}, '{4'd9, 16'h0020}, '{4'd10, 16'h0010}, '{4'd11, 16'h0008},
      '{4'd12, 16'h0004}, '{4'd13, 16'h0002}, '{4'd14, 16'h0001}, '{4'd15, 16'h0000}
    };
    sv = '{
      '{16'h2500, 16'h22F9, 16'h3599},
      '{16'h0000, 16'h0000, 16'h4000},
      '{16'hDB00, 16'hDD07, 16'h3599},
      '{16'h3244, 16'h2D41, 16'h2D41}
    };
    rst = 1'b1;
    bus.load = 1'b1;
    bus.addr = 4'd0;
    bus.endangle = 16'h2500;
    tick();
    chk("reset_sin", bus.sin, 16'h0000, 0);
    chk("reset_cos", bus.cos, 16'h0000, 0);
    chk("reset_z", bus.currentangle, 16'h0000, 0);
    chk("reset_data", bus.data, 16'h3244, 0);
    bus.load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.addr = rv[i].a;
      #1;
      chk($sformatf("rom_%0d", i), bus.data, rv[i].d, 0);
    end
    rst = 1'b0;
    start(16'h2500);
    chk("it0_cos", bus.cos, 16'h26DD, 0);
    chk("it0_sin", bus.sin, 16'h26DD, 0);
    chk("it0_z", bus.currentangle, 16'h3244, 0);
    bus.addr = 4'd1;
    tick();
    chk("it1_cos", bus.cos, 16'h3A4B, 0);
    chk("it1_sin", bus.sin, 16'h136F, 0);
    chk("it1_z", bus.currentangle, 16'h1498, 0);
    start(16'hDB00);
    chk("neg0_cos", bus.cos, 16'h26DD, 0);
    chk("neg0_sin", bus.sin, 16'hD923, 0);
    chk("neg0_z", bus.currentangle, 16'hCDBC, 0);
    for (int v = 0; v < 4; v++) begin
      run_seq(sv[v].ang);
      chk($sformatf("seq%0d_sin", v), bus.sin, sv[v].s, 8);
      chk($sformatf("seq%0d_cos", v), bus.cos, sv[v].c, 8);
      chk($sformatf("seq%0d_z", v), bus.currentangle, sv[v].ang, 16);
    end
    start(16'h2500);
    for (int i = 1; i < 7; i++) begin
      bus.addr = 4'(i);
      tick();
    end
    bus.addr = 4'd7;
    bus.load = 1'b1;
    rst = 1'b1;
    tick();
    chk("midrst_sin", bus.sin, 16'h0000, 0);
    chk("midrst_cos", bus.cos, 16'h0000, 0);
    chk("midrst_z", bus.currentangle, 16'h0000, 0);
    chk("midrst_data", bus.data, 16'h0080, 0);
    rst = 1'b0;
    bus.load = 1'b0;
    run_seq(16'h2500);
    chk("restart_sin", bus.sin, 16'h22F9, 8);
    chk("restart_cos", bus.cos, 16'h3599, 8);
    chk("restart_z", bus.currentangle, 16'h2500, 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
